object_field_tracker: RTL and testbench
=======================================

Name: object_field_tracker

Overview:
- Parametrised manager for N on-screen pickup objects (gold/diamond/stone) in GoldMiner; runs on the 60 Hz frame clock.
- Loads a level's object positions and values, attaches a hit object to the hook, and collects it when the hook returns.
- Tracks remaining objects, cumulative score and level-clear.
- Feeds flattened object positions to the per-object sprite address generators on the pixel clock side.

Parameters:
- N_OBJ, 10, number of tracked objects (1..16)
- IDX_W, 4, width of object index (ceil(log2(N_OBJ)), min 1)
- XW, 11, x coordinate width
- YW, 10, y coordinate width
- VW, 8, per-object value width
- SW, 16, score width
- PARK_X, 2000, off-screen x for removed/unloaded objects
- PARK_Y, 900, off-screen y for removed/unloaded objects

Ports:
- pixclk_60  in  1  frame-rate clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- load  in  1  start level: latch init vectors (one-cycle pulse)
- init_mask  in  N_OBJ  objects present in level
- init_x  in  N_OBJ*XW  flattened start x, object i at [i*XW +: XW]
- init_y  in  N_OBJ*YW  flattened start y
- init_val  in  N_OBJ*VW  flattened object values
- game_state  in  2  00 waving, 01 stretching, 10 hitting, 11 missing
- hit_valid  in  1  hook collision this cycle
- hit_idx  in  IDX_W  index of collided object
- hook_x  in  XW  hook block x
- hook_y  in  YW  hook block y
- obj_x  out  N_OBJ*XW  current object x, flattened
- obj_y  out  N_OBJ*YW  current object y, flattened
- obj_active  out  N_OBJ  object present (visible or carried)
- attached_valid  out  1  an object is on the hook
- attached_idx  out  IDX_W  index of carried object
- collect_pulse  out  1  one-cycle strobe on collection
- score  out  SW  cumulative score
- remaining  out  IDX_W+1  active object count
- level_clear  out  1  all objects collected

Behaviour:
- Reset values (sync rst, priority over everything):
  - all obj_x = PARK_X, all obj_y = PARK_Y
  - obj_active = 0, attached_valid = 0, attached_idx = 0
  - collect_pulse = 0, score = 0, remaining = 0, level_clear = 0
  - FSM = IDLE
- All outputs are registered.
- FSM states: IDLE, PLAY, CARRY, COLLECT.
- load, any state (priority below rst, above all else), next cycle:
  - obj i: x/y = init values if init_mask[i], else PARK
  - obj_active = init_mask; remaining = popcount(init_mask)
  - attached_valid = 0, level_clear = 0; score unchanged
  - FSM = PLAY, or IDLE with level_clear = 1 if init_mask == 0
  - A collection pending in the same cycle is discarded (no score, no pulse).
- IDLE: holds all outputs; hit_valid ignored.
- PLAY → CARRY, next cycle, when all hold:
  - hit_valid = 1, game_state = 10, hit_idx < N_OBJ, obj_active[hit_idx] = 1
  - Effects: attached_idx = hit_idx, attached_valid = 1.
  - Any other hit_valid (wrong state, out-of-range index, inactive object) is ignored.
- CARRY:
  - Each cycle, attached object's x/y follow hook_x/hook_y with 1-cycle latency.
  - The attach cycle already loads the hook position.
  - hit_valid ignored.
  - game_state = 00 → COLLECT next cycle; the object still follows on that edge.
- COLLECT, single cycle, on exit edge:
  - Attached object: x/y = PARK, obj_active bit = 0.
  - score += init_val of object, saturating at 2^SW-1.
  - remaining -= 1, collect_pulse = 1 for one cycle, attached_valid = 0.
  - If remaining reaches 0: level_clear = 1, FSM → IDLE; else FSM → PLAY.
- Values are latched at load; later changes to init_* have no effect until the next load.
- Objects not attached never move.
- level_clear is held until load or rst.

Test Plan:
- rst mid-CARRY (obj 3 attached) → next cycle all positions (2000,900), obj_active = 0, score = 0, attached_valid = 0, IDLE.
- load, init_mask = 10'h3FF, obj5 at (300,400) val 50 → obj_x[5] = 300, obj_y[5] = 400, remaining = 10, level_clear = 0.
- hit_valid with game_state = 10, hit_idx = 5, hook (310,200)→(310,260) over 3 frames → obj5 tracks each hook position one cycle later. Then game_state = 00 → collect_pulse once, score = 50, obj5 parked, remaining = 9.
- Illegal hits → no state change:
  - hit_idx = 12
  - hit_idx = 5 again (already inactive)
  - game_state = 01 with a valid index
- Clear level: load init_mask = 10'h001 with val 255, collect it → level_clear = 1, IDLE. A subsequent hit is ignored. Next load clears level_clear, score retained at prior + 255.
- Score saturation (SW = 8, score 250, collect val 20) → score = 255. Separately: load asserted in the same cycle as COLLECT → reload wins, no collect_pulse, score unchanged.

Source files
------------

// File: rtl/object_field_tracker.sv
// Frame-rate manager for GoldMiner pickup objects: level loading, hook attach,
// carry-follow and collection with saturating score and level-clear tracking.
module object_field_tracker #(
  parameter int N_OBJ  = 10,
  parameter int IDX_W  = 4,
  parameter int XW     = 11,
  parameter int YW     = 10,
  parameter int VW     = 8,
  parameter int SW     = 16,
  parameter int PARK_X = 2000,
  parameter int PARK_Y = 900
) (
  input  logic                 pixclk_60,
  input  logic                 rst,
  input  logic                 load,
  input  logic [N_OBJ-1:0]     init_mask,
  input  logic [N_OBJ*XW-1:0]  init_x,
  input  logic [N_OBJ*YW-1:0]  init_y,
  input  logic [N_OBJ*VW-1:0]  init_val,
  input  logic [1:0]           game_state,
  input  logic                 hit_valid,
  input  logic [IDX_W-1:0]     hit_idx,
  input  logic [XW-1:0]        hook_x,
  input  logic [YW-1:0]        hook_y,
  output logic [N_OBJ*XW-1:0]  obj_x,
  output logic [N_OBJ*YW-1:0]  obj_y,
  output logic [N_OBJ-1:0]     obj_active,
  output logic                 attached_valid,
  output logic [IDX_W-1:0]     attached_idx,
  output logic                 collect_pulse,
  output logic [SW-1:0]        score,
  output logic [IDX_W:0]       remaining,
  output logic                 level_clear
);

  typedef enum logic [1:0] {IDLE, PLAY, CARRY, COLLECT} state_t;

  localparam logic [XW-1:0] PARK_XV = XW'(PARK_X);
  localparam logic [YW-1:0] PARK_YV = YW'(PARK_Y);
  localparam int PAD_W = 2 ** IDX_W;

  state_t               state_q, state_d;
  logic [N_OBJ*XW-1:0]  objX_q, objX_d;
  logic [N_OBJ*YW-1:0]  objY_q, objY_d;
  logic [N_OBJ*VW-1:0]  val_q, val_d;
  logic [N_OBJ-1:0]     active_q, active_d;
  logic                 attValid_q, attValid_d;
  logic [IDX_W-1:0]     attIdx_q, attIdx_d;
  logic                 collect_q, collect_d;
  logic [SW-1:0]        score_q, score_d;
  logic [IDX_W:0]       remaining_q, remaining_d;
  logic                 clear_q, clear_d;

  logic [IDX_W:0]       maskCount;
  logic [PAD_W-1:0]     activePad;
  logic                 hitOk;
  logic [SW:0]          scoreSum;

  always_comb begin
    maskCount = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      maskCount = maskCount + (IDX_W+1)'(init_mask[i]);
    end
  end

  // Padding the active vector to the full index range makes out-of-range hits read as inactive.
  assign activePad = PAD_W'(active_q);
  assign hitOk     = hit_valid && (game_state == 2'b10) &&
                     (int'(hit_idx) < N_OBJ) && activePad[hit_idx];
  assign scoreSum  = (SW+1)'(score_q) + (SW+1)'(val_q[int'(attIdx_q)*VW +: VW]);

  always_comb begin
    state_d     = state_q;
    objX_d      = objX_q;
    objY_d      = objY_q;
    val_d       = val_q;
    active_d    = active_q;
    attValid_d  = attValid_q;
    attIdx_d    = attIdx_q;
    collect_d   = 1'b0;
    score_d     = score_q;
    remaining_d = remaining_q;
    clear_d     = clear_q;

    if (load) begin
      for (int i = 0; i < N_OBJ; i++) begin
        objX_d[i*XW +: XW] = init_mask[i] ? init_x[i*XW +: XW] : PARK_XV;
        objY_d[i*YW +: YW] = init_mask[i] ? init_y[i*YW +: YW] : PARK_YV;
      end
      val_d       = init_val;
      active_d    = init_mask;
      remaining_d = maskCount;
      attValid_d  = 1'b0;
      clear_d     = (init_mask == '0);
      state_d     = (init_mask == '0) ? IDLE : PLAY;
    end else begin
      unique case (state_q)
        IDLE: ;
        PLAY: begin
          if (hitOk) begin
            attIdx_d   = hit_idx;
            attValid_d = 1'b1;
            objX_d[int'(hit_idx)*XW +: XW] = hook_x;
            objY_d[int'(hit_idx)*YW +: YW] = hook_y;
            state_d    = CARRY;
          end
        end
        CARRY: begin
          objX_d[int'(attIdx_q)*XW +: XW] = hook_x;
          objY_d[int'(attIdx_q)*YW +: YW] = hook_y;
          if (game_state == 2'b00) state_d = COLLECT;
        end
        COLLECT: begin
          objX_d[int'(attIdx_q)*XW +: XW] = PARK_XV;
          objY_d[int'(attIdx_q)*YW +: YW] = PARK_YV;
          active_d[attIdx_q] = 1'b0;
          score_d     = scoreSum[SW] ? '1 : scoreSum[SW-1:0];
          remaining_d = remaining_q - (IDX_W+1)'(1);
          collect_d   = 1'b1;
          attValid_d  = 1'b0;
          if (remaining_q == (IDX_W+1)'(1)) begin
            clear_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PLAY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pixclk_60) begin
    if (rst) begin
      state_q     <= IDLE;
      objX_q      <= {N_OBJ{PARK_XV}};
      objY_q      <= {N_OBJ{PARK_YV}};
      val_q       <= '0;
      active_q    <= '0;
      attValid_q  <= 1'b0;
      attIdx_q    <= '0;
      collect_q   <= 1'b0;
      score_q     <= '0;
      remaining_q <= '0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      objX_q      <= objX_d;
      objY_q      <= objY_d;
      val_q       <= val_d;
      active_q    <= active_d;
      attValid_q  <= attValid_d;
      attIdx_q    <= attIdx_d;
      collect_q   <= collect_d;
      score_q     <= score_d;
      remaining_q <= remaining_d;
      clear_q     <= clear_d;
    end
  end

  assign obj_x          = objX_q;
  assign obj_y          = objY_q;
  assign obj_active     = active_q;
  assign attached_valid = attValid_q;
  assign attached_idx   = attIdx_q;
  assign collect_pulse  = collect_q;
  assign score          = score_q;
  assign remaining      = remaining_q;
  assign level_clear    = clear_q;

endmodule

// File: tb/tb_object_field_tracker.sv
// Bench for object_field_tracker: directed level scenarios followed by random play,
// all checked against an object-list reference model (16-bit and 8-bit score instances).
module tb_object_field_tracker;

  localparam int N     = 10;
  localparam int IDX_W = 4;
  localparam int XW    = 11;
  localparam int YW    = 10;
  localparam int VW    = 8;

  logic              pixclk_60 = 1'b0;
  logic              rst = 1'b1;
  logic              load = 1'b0;
  logic [N-1:0]      init_mask = '0;
  logic [N*XW-1:0]   init_x = '0;
  logic [N*YW-1:0]   init_y = '0;
  logic [N*VW-1:0]   init_val = '0;
  logic [1:0]        game_state = 2'b00;
  logic              hit_valid = 1'b0;
  logic [IDX_W-1:0]  hit_idx = '0;
  logic [XW-1:0]     hook_x = '0;
  logic [YW-1:0]     hook_y = '0;

  logic [N*XW-1:0]   obj_x, obj_x8;
  logic [N*YW-1:0]   obj_y, obj_y8;
  logic [N-1:0]      obj_active, obj_active8;
  logic              attached_valid, attached_valid8;
  logic [IDX_W-1:0]  attached_idx, attached_idx8;
  logic              collect_pulse, collect_pulse8;
  logic [15:0]       score;
  logic [7:0]        score8;
  logic [IDX_W:0]    remaining, remaining8;
  logic              level_clear, level_clear8;

  int compared = 0;
  int mismatched = 0;

  object_field_tracker dut (
    .pixclk_60(pixclk_60), .rst(rst), .load(load), .init_mask(init_mask),
    .init_x(init_x), .init_y(init_y), .init_val(init_val), .game_state(game_state),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .hook_x(hook_x), .hook_y(hook_y),
    .obj_x(obj_x), .obj_y(obj_y), .obj_active(obj_active),
    .attached_valid(attached_valid), .attached_idx(attached_idx),
    .collect_pulse(collect_pulse), .score(score), .remaining(remaining),
    .level_clear(level_clear)
  );

  object_field_tracker #(.SW(8)) dut8 (
    .pixclk_60(pixclk_60), .rst(rst), .load(load), .init_mask(init_mask),
    .init_x(init_x), .init_y(init_y), .init_val(init_val), .game_state(game_state),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .hook_x(hook_x), .hook_y(hook_y),
    .obj_x(obj_x8), .obj_y(obj_y8), .obj_active(obj_active8),
    .attached_valid(attached_valid8), .attached_idx(attached_idx8),
    .collect_pulse(collect_pulse8), .score(score8), .remaining(remaining8),
    .level_clear(level_clear8)
  );

  always #5 pixclk_60 = ~pixclk_60;

  // Reference model: a list of objects plus a "what is the hook doing" phase.
  int  mx[N], my[N], mval[N];
  bit  mact[N];
  int  mPhase;
  bit  mAtt, mPulse, mClear;
  int  mAttIdx, mRem, mScore16, mScore8;

  task automatic modelStep();
    int cnt;
    mPulse = 0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mx[i] = 2000; my[i] = 900; mact[i] = 0; mval[i] = 0;
      end
      mPhase = 0; mAtt = 0; mAttIdx = 0; mClear = 0; mRem = 0;
      mScore16 = 0; mScore8 = 0;
    end else if (load) begin
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        mact[i] = init_mask[i];
        mx[i]   = init_mask[i] ? int'(init_x[i*XW +: XW]) : 2000;
        my[i]   = init_mask[i] ? int'(init_y[i*YW +: YW]) : 900;
        mval[i] = int'(init_val[i*VW +: VW]);
        cnt += int'(init_mask[i]);
      end
      mRem = cnt; mAtt = 0; mClear = (cnt == 0);
      mPhase = (cnt == 0) ? 0 : 1;
    end else if (mPhase == 1) begin
      if (hit_valid && game_state == 2 && int'(hit_idx) < N && mact[int'(hit_idx)]) begin
        mAttIdx = int'(hit_idx); mAtt = 1;
        mx[mAttIdx] = int'(hook_x); my[mAttIdx] = int'(hook_y);
        mPhase = 2;
      end
    end else if (mPhase == 2) begin
      mx[mAttIdx] = int'(hook_x); my[mAttIdx] = int'(hook_y);
      if (game_state == 0) mPhase = 3;
    end else if (mPhase == 3) begin
      mx[mAttIdx] = 2000; my[mAttIdx] = 900; mact[mAttIdx] = 0;
      mScore16 = (mScore16 + mval[mAttIdx] > 65535) ? 65535 : mScore16 + mval[mAttIdx];
      mScore8  = (mScore8 + mval[mAttIdx] > 255) ? 255 : mScore8 + mval[mAttIdx];
      mRem--; mPulse = 1; mAtt = 0;
      if (mRem == 0) begin
        mClear = 1; mPhase = 0;
      end else begin
        mPhase = 1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("x%0d", i), longint'(obj_x[i*XW +: XW]), longint'(mx[i]));
      checkOutput($sformatf("y%0d", i), longint'(obj_y[i*YW +: YW]), longint'(my[i]));
      checkOutput($sformatf("act%0d", i), longint'(obj_active[i]), longint'(mact[i]));
    end
    checkOutput("attached_valid", longint'(attached_valid), longint'(mAtt));
    if (mAtt) checkOutput("attached_idx", longint'(attached_idx), longint'(mAttIdx));
    checkOutput("collect_pulse", longint'(collect_pulse), longint'(mPulse));
    checkOutput("score", longint'(score), longint'(mScore16));
    checkOutput("score8", longint'(score8), longint'(mScore8));
    checkOutput("remaining", longint'(remaining), longint'(mRem));
    checkOutput("level_clear", longint'(level_clear), longint'(mClear));
  endtask

  // One frame: drive inputs, let the edge happen, advance the model, then compare.
  task automatic applyStimulus(input bit r, input bit ld, input logic [1:0] gs, input bit hv,
                               input int hidx, input int hx, input int hy);
    rst = r; load = ld; game_state = gs; hit_valid = hv;
    hit_idx = IDX_W'(hidx); hook_x = XW'(hx); hook_y = YW'(hy);
    @(posedge pixclk_60);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic setObj(input int i, input int x, input int y, input int v);
    init_x[i*XW +: XW]   = XW'(x);
    init_y[i*YW +: YW]   = YW'(y);
    init_val[i*VW +: VW] = VW'(v);
  endtask

  task automatic randomInit();
    for (int i = 0; i < N; i++) setObj(i, $urandom_range(0, 1279), $urandom_range(0, 719), $urandom_range(0, 255));
  endtask

  initial begin
    $display("[TB] start");
    #1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Reset while carrying object 3
    randomInit();
    init_mask = 10'h3FF;
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 2, 1, 3, 100, 100);
    applyStimulus(0, 0, 2, 0, 3, 120, 140);
    applyStimulus(1, 0, 2, 0, 3, 130, 150);
    checkOutput("rst_x3", longint'(obj_x[3*XW +: XW]), 2000);
    checkOutput("rst_active", longint'(obj_active), 0);

    // Full level; collect object 5
    randomInit();
    setObj(5, 300, 400, 50);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("load_x5", longint'(obj_x[5*XW +: XW]), 300);
    checkOutput("load_y5", longint'(obj_y[5*YW +: YW]), 400);
    checkOutput("load_rem", longint'(remaining), 10);
    applyStimulus(0, 0, 2, 1, 5, 310, 200);
    applyStimulus(0, 0, 2, 0, 5, 310, 230);
    applyStimulus(0, 0, 2, 0, 5, 310, 260);
    checkOutput("track_y5", longint'(obj_y[5*YW +: YW]), 260);
    applyStimulus(0, 0, 0, 0, 5, 310, 280);
    applyStimulus(0, 0, 0, 0, 5, 310, 290);
    checkOutput("collect_score", longint'(score), 50);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Illegal hits
    applyStimulus(0, 0, 2, 1, 12, 50, 50);
    applyStimulus(0, 0, 2, 1, 5, 50, 50);
    applyStimulus(0, 0, 1, 1, 4, 50, 50);
    applyStimulus(0, 0, 3, 1, 4, 50, 50);

    // Single-object level clears, then reload
    init_mask = 10'h001;
    setObj(0, 40, 60, 255);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 2, 1, 0, 70, 80);
    applyStimulus(0, 0, 0, 0, 0, 70, 90);
    applyStimulus(0, 0, 0, 0, 0, 70, 95);
    checkOutput("clear_flag", longint'(level_clear), 1);
    checkOutput("clear_score", longint'(score), 305);
    applyStimulus(0, 0, 2, 1, 0, 70, 80);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    init_mask = 10'h0F0;
    applyStimulus(0, 1, 0, 0, 0, 0, 0);

    // Saturation on the 8-bit score instance
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    init_mask = 10'h003;
    setObj(0, 10, 10, 250);
    setObj(1, 20, 20, 20);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 2, 1, k, 5, 5);
      applyStimulus(0, 0, 0, 0, k, 6, 6);
      applyStimulus(0, 0, 0, 0, k, 7, 7);
    end
    checkOutput("sat_score8", longint'(score8), 255);

    // Load in the COLLECT cycle discards the collection
    init_mask = 10'h0FF;
    randomInit();
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 2, 1, 2, 9, 9);
    applyStimulus(0, 0, 0, 0, 2, 9, 9);
    applyStimulus(0, 1, 0, 0, 2, 9, 9);
    checkOutput("reload_pulse", longint'(collect_pulse), 0);

    // Random play
    for (int c = 0; c < 3000; c++) begin
      bit r, ld;
      randomInit();
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 29) == 0);
      if (ld) init_mask = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      applyStimulus(r, ld, 2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                    $urandom_range(0, 15), $urandom_range(0, 2047), $urandom_range(0, 1023));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
